pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/stall_timeout_cnt.sv | 36 +++
 rtl/pipeline_stall_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2,
    BR_FLUSH = 2'd3
  } stall_state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_we;
    logic exmem_bubble;
  } pipe_ctl_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam pipe_ctl_t CTL_RUN = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, exmem_we: 1'b1, exmem_bubble: 1'b0};
  localparam pipe_ctl_t CTL_RESET = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, exmem_we: 1'b0, exmem_bubble: 1'b1};
  localparam pipe_ctl_t CTL_FREEZE = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b0, exmem_we: 1'b0, exmem_bubble: 1'b0};
  localparam pipe_ctl_t CTL_MD_STALL = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                         idex_bubble: 1'b0, exmem_we: 1'b0, exmem_bubble: 1'b1};

endpackage

// File: rtl/stall_timeout_cnt.sv
// Mul/div timeout counter: load to 1 on the start cycle, increment per busy cycle,
// terminal count flags the last allowed stall cycle.
module stall_timeout_cnt #(
  parameter int unsigned TERMINAL = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned W = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(1);
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == W'(TERMINAL - 1));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (Mealy outputs).
// Optional stall-cycle performance counter enabled by `define STALL_PERF_EN.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BR_PENALTY = 2,
  parameter int unsigned MD_TIMEOUT = 64
`ifdef STALL_PERF_EN
  , parameter int unsigned CNT_W    = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic lu_hazard,
  input  logic br_taken,
  input  logic md_start,
  input  logic md_done,
  input  logic dmem_req,
  input  logic dmem_ready,
  output logic pc_we,
  output logic ifid_we,
  output logic ifid_flush,
  output logic idex_bubble,
  output logic exmem_we,
  output logic exmem_bubble,
  output logic md_err
`ifdef STALL_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] BR_RELOAD = FLUSH_CNT_W'(BR_PENALTY - 1);

  stall_state_t state_q, state_d, saved_q, saved_d, eff_state;
  logic [FLUSH_CNT_W-1:0] flush_q, flush_d;
  logic pend_q, pend_d, md_err_q, md_err_d, rst_q;
  logic freeze, md_done_eff, md_stall, to_load, to_inc, to_tc;
  pipe_ctl_t ctl;

  // MEM_WAIT replays the interrupted state once memory responds.
  assign eff_state   = (state_q == MEM_WAIT) ? saved_q : state_q;
  assign freeze      = (state_q == MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
  assign md_done_eff = md_done || pend_q;
  assign md_stall    = md_start && !md_done && ((eff_state == RUN) || (eff_state == BR_FLUSH));

  stall_timeout_cnt #(.TERMINAL(MD_TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load_i (to_load),
    .inc_i  (to_inc),
    .tc_o   (to_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      saved_q  <= RUN;
      flush_q  <= '0;
      pend_q   <= 1'b0;
      md_err_q <= 1'b0;
      rst_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      flush_q  <= flush_d;
      pend_q   <= pend_d;
      md_err_q <= md_err_d;
      rst_q    <= 1'b0;
    end
  end

  // The cycle right after reset is still a reset cycle: no events accepted.
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    flush_d  = flush_q;
    pend_d   = pend_q;
    md_err_d = md_err_q;
    to_load  = 1'b0;
    to_inc   = 1'b0;
    if (!rst_q) begin
      if (freeze) begin
        state_d = MEM_WAIT;
        saved_d = eff_state;
        pend_d  = pend_q || ((eff_state == MD_BUSY) && md_done);
      end else begin
        pend_d  = 1'b0;
        saved_d = RUN;
        case (eff_state)
          MD_BUSY: begin
            if (md_done_eff) begin
              state_d = RUN;
            end else if (to_tc) begin
              state_d  = RUN;
              md_err_d = 1'b1;
            end else begin
              state_d = MD_BUSY;
              to_inc  = 1'b1;
            end
          end
          BR_FLUSH: begin
            if (md_stall) begin
              state_d = MD_BUSY;
              to_load = 1'b1;
            end else if (br_taken) begin
              state_d = BR_FLUSH;
              flush_d = BR_RELOAD;
            end else if (flush_q <= FLUSH_CNT_W'(1)) begin
              state_d = RUN;
              flush_d = '0;
            end else begin
              state_d = BR_FLUSH;
              flush_d = flush_q - FLUSH_CNT_W'(1);
            end
          end
          default: begin
            if (md_stall) begin
              state_d = MD_BUSY;
              to_load = 1'b1;
            end else if (br_taken) begin
              state_d = (BR_PENALTY > 1) ? BR_FLUSH : RUN;
              flush_d = BR_RELOAD;
            end else begin
              state_d = RUN;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    ctl = CTL_RUN;
    if (rst || rst_q) begin
      ctl = CTL_RESET;
    end else if (freeze) begin
      ctl = CTL_FREEZE;
    end else begin
      case (eff_state)
        MD_BUSY: begin
          if (!md_done_eff) ctl = CTL_MD_STALL;
        end
        BR_FLUSH: begin
          if (md_stall) begin
            ctl = CTL_MD_STALL;
          end else begin
            ctl.ifid_flush  = 1'b1;
            ctl.idex_bubble = br_taken;
          end
        end
        default: begin
          if (md_stall) begin
            ctl = CTL_MD_STALL;
          end else if (br_taken) begin
            ctl.ifid_flush  = 1'b1;
            ctl.idex_bubble = 1'b1;
          end else if (lu_hazard) begin
            ctl.pc_we       = 1'b0;
            ctl.ifid_we     = 1'b0;
            ctl.idex_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  assign pc_we        = ctl.pc_we;
  assign ifid_we      = ctl.ifid_we;
  assign ifid_flush   = ctl.ifid_flush;
  assign idex_bubble  = ctl.idex_bubble;
  assign exmem_we     = ctl.exmem_we;
  assign exmem_bubble = ctl.exmem_bubble;
  assign md_err       = md_err_q && !rst;

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of non-reset cycles with the PC held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!rst_q && !ctl.pc_we && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (BR_PENALTY=2, MD_TIMEOUT=8).
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lu_hazard = 1'b0, br_taken = 1'b0, md_start = 1'b0, md_done = 1'b0;
  logic dmem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, exmem_bubble, md_err;
`ifdef STALL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, exmem_bubble, md_err}
  localparam logic [6:0] E_RUN = 7'b1100100;
  localparam logic [6:0] E_RST = 7'b0011010;
  localparam logic [6:0] E_FRZ = 7'b0000000;
  localparam logic [6:0] E_LU  = 7'b0001100;
  localparam logic [6:0] E_BR  = 7'b1111100;
  localparam logic [6:0] E_BRF = 7'b1110100;
  localparam logic [6:0] E_MD  = 7'b0000010;

  typedef struct {
    string      name;
    logic       r, l, b, s, d, q, y;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  pipeline_stall_ctrl #(.BR_PENALTY(2), .MD_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .lu_hazard    (lu_hazard),
    .br_taken     (br_taken),
    .md_start     (md_start),
    .md_done      (md_done),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_we     (exmem_we),
    .exmem_bubble (exmem_bubble),
    .md_err       (md_err)
`ifdef STALL_PERF_EN
    , .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic add(input string n, input logic r, l, b, s, d, q, y, input logic [6:0] e);
    vec_t v;
    v.name = n; v.r = r; v.l = l; v.b = b; v.s = s; v.d = d; v.q = q; v.y = y; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic r, l, b, s, d, q, y);
    @(negedge clk);
    rst = r; lu_hazard = l; br_taken = b; md_start = s; md_done = d;
    dmem_req = q; dmem_ready = y;
    #1;
  endtask

  task automatic chk(input string n, input logic [6:0] exp);
    logic [6:0] act;
    act = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, exmem_bubble, md_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

`ifdef STALL_PERF_EN
  task automatic chk_cnt(input string n, input logic [15:0] exp);
    checks++;
    if (stall_cnt !== exp) begin
      errors++;
      $display("FAIL %s: stall_cnt got %h expected %h", n, stall_cnt, exp);
    end
  endtask
`endif

  initial begin
    //      name          rst lu br ms md rq ry  expected
    add("rst",          1, 0, 0, 0, 0, 0, 0, E_RST);
    add("post_rst",     0, 0, 0, 0, 0, 0, 0, E_RST);
    add("idle",         0, 0, 0, 0, 0, 0, 0, E_RUN);
    add("lu",           0, 1, 0, 0, 0, 0, 0, E_LU);
    add("lu_after",     0, 0, 0, 0, 0, 0, 0, E_RUN);
    add("br_lu_c1",     0, 1, 1, 0, 0, 0, 0, E_BR);
    add("br_lu_c2",     0, 1, 0, 0, 0, 0, 0, E_BRF);
    add("br_done",      0, 0, 0, 0, 0, 0, 0, E_RUN);
    add("br_a",         0, 0, 1, 0, 0, 0, 0, E_BR);
    add("br_restart",   0, 0, 1, 0, 0, 0, 0, E_BR);
    add("br_restart_f", 0, 0, 0, 0, 0, 0, 0, E_BRF);
    add("br_restart_r", 0, 0, 0, 0, 0, 0, 0, E_RUN);
    add("md_c0",        0, 0, 0, 1, 0, 0, 0, E_MD);
    add("md_c1",        0, 0, 0, 0, 0, 0, 0, E_MD);
    add("md_c2",        0, 0, 0, 0, 0, 0, 0, E_MD);
    add("md_c3",        0, 0, 0, 0, 0, 0, 0, E_MD);
    add("md_c4",        0, 0, 0, 0, 0, 0, 0, E_MD);
    add("md_done",      0, 0, 0, 0, 1, 0, 0, E_RUN);
    add("md_run",       0, 0, 0, 0, 0, 0, 0, E_RUN);
    add("md_zero",      0, 0, 0, 1, 1, 0, 0, E_RUN);
    add("md_zero_nxt",  0, 0, 0, 0, 0, 0, 0, E_RUN);
    add("mw_md_c0",     0, 0, 0, 1, 0, 0, 0, E_MD);
    add("mw_md_c1",     0, 0, 0, 0, 0, 0, 0, E_MD);
    add("mw_frz1",      0, 0, 0, 0, 0, 1, 0, E_FRZ);
    add("mw_frz2_done", 0, 0, 0, 0, 1, 1, 0, E_FRZ);
    add("mw_frz3",      0, 0, 0, 0, 0, 1, 0, E_FRZ);
    add("mw_exit_md",   0, 0, 0, 0, 0, 1, 1, E_RUN);
    add("mw_not_lost",  0, 0, 0, 0, 0, 0, 0, E_RUN);
    add("mw_run_frz",   0, 1, 0, 0, 0, 1, 0, E_FRZ);
    add("mw_run_lu",    0, 1, 0, 0, 0, 1, 1, E_LU);
    add("mw_run_idle",  0, 0, 0, 0, 0, 0, 0, E_RUN);
    add("mw_br",        0, 0, 1, 0, 0, 0, 0, E_BR);
    add("mw_br_frz",    0, 0, 0, 0, 0, 1, 0, E_FRZ);
    add("mw_br_resume", 0, 0, 0, 0, 0, 1, 1, E_BRF);
    add("mw_br_run",    0, 0, 0, 0, 0, 0, 0, E_RUN);
    add("rb_br",        0, 0, 1, 0, 0, 0, 0, E_BR);
    add("rb_rst",       1, 0, 0, 0, 0, 0, 0, E_RST);
    add("rb_post",      0, 0, 0, 0, 0, 0, 0, E_RST);
    add("rb_run",       0, 0, 0, 0, 0, 0, 0, E_RUN);
    add("rm_md",        0, 0, 0, 1, 0, 0, 0, E_MD);
    add("rm_rst",       1, 0, 0, 0, 0, 0, 0, E_RST);
    add("rm_post_lu",   0, 1, 0, 0, 0, 0, 0, E_RST);
    add("rm_run",       0, 0, 0, 0, 0, 0, 0, E_RUN);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].l, vecs[i].b, vecs[i].s, vecs[i].d, vecs[i].q, vecs[i].y);
      chk(vecs[i].name, vecs[i].exp);
    end

    // Mul/div timeout: 8 stall cycles, then md_err sticks until reset.
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("to_c0", E_MD);
    for (int i = 1; i < 8; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("to_c%0d", i), E_MD);
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("to_err_run", E_RUN | 7'b0000001);
    apply(0, 1, 0, 0, 0, 0, 0);
    chk("to_sticky_lu", E_LU | 7'b0000001);
    apply(0, 0, 0, 1, 1, 0, 0);
    chk("to_sticky_md", E_RUN | 7'b0000001);
    apply(1, 0, 0, 0, 0, 0, 0);
    chk("to_rst", E_RST);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("to_post", E_RST);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("to_cleared", E_RUN);

`ifdef STALL_PERF_EN
    // Reset from BR_FLUSH clears the counter, then it saturates under a held stall.
    apply(0, 0, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk_cnt("perf_rst", 16'h0000);
    for (int i = 0; i < 65540; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0);
      if (i < 3 || i >= 65533) begin
        chk_cnt($sformatf("perf_%0d", i), (i >= 65535) ? 16'hFFFF : 16'(i));
        chk($sformatf("perf_lu_%0d", i), E_LU);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
